// File: rtl/ps2_scancode_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scancode_receiver_if                                                 |
// | Key-event bus from the PS/2 receiver to the keycode mapper.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ps2_scancode_receiver_if;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;
  logic       extended;
  logic       frame_err;

  modport master (output valid, makeBreak, outCode, extended, frame_err);
  modport slave  (input  valid, makeBreak, outCode, extended, frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_scancode_receiver                                                    |
// | PS/2 line conditioning, frame deserialiser and E0/F0 prefix stripper.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ps2_scancode_receiver #(
  parameter int CLK_FILTER     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  wire                     CLOCK_50,
  input  wire                     reset,
  input  wire                     PS2_CLK,
  input  wire                     PS2_DAT,
  ps2_scancode_receiver_if.master evt
);

  localparam int                   c_FLT_W    = (CLK_FILTER > 1) ? $clog2(CLK_FILTER) : 1;
  localparam logic [c_FLT_W-1:0]   c_FLT_LAST = c_FLT_W'(CLK_FILTER - 1);
  localparam logic [c_FLT_W-1:0]   c_FLT_ONE  = c_FLT_W'(1);
  localparam logic [TIMEOUT_W-1:0] c_TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] c_TO_ONE   = TIMEOUT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                 r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic                 r_clk_flt;
  logic [c_FLT_W-1:0]   r_flt_cnt;
  state_t               r_state;
  logic [2:0]           r_bitcnt;
  logic [7:0]           r_shift;
  logic                 r_parity;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic                 r_byte_rdy;
  logic                 r_ext_pend, r_brk_pend;
  logic                 r_valid, r_make, r_ext, r_err;
  logic [7:0]           r_code;

  logic w_fall;
  logic w_parity_ok;

  // The filtered clock flips on the same cycle that this term is high.
  assign w_fall      = r_clk_flt & ~r_clk_sync & (r_flt_cnt == c_FLT_LAST);
  assign w_parity_ok = ^{r_shift, r_parity};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_clk_flt  <= 1'b1;
      r_flt_cnt  <= '0;
    end else begin
      r_clk_meta <= PS2_CLK;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= PS2_DAT;
      r_dat_sync <= r_dat_meta;
      if (r_clk_sync == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_FLT_LAST) begin
        r_clk_flt <= r_clk_sync;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + c_FLT_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_byte_rdy <= 1'b0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_valid    <= 1'b0;
      r_make     <= 1'b0;
      r_ext      <= 1'b0;
      r_code     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;

      // A fall on the terminal count takes priority, so no timeout fires then.
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_sync) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_dat_sync, r_shift[7:1]};
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
            else                  r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PARITY: begin
            r_parity <= r_dat_sync;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (r_dat_sync && w_parity_ok) begin
              r_byte_rdy <= 1'b1;
            end else begin
              r_err      <= 1'b1;
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_TO_LAST) begin
        r_state    <= S_IDLE;
        r_to_cnt   <= '0;
        r_err      <= 1'b1;
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + c_TO_ONE;
      end

      // The shift register is untouched until the next frame's data bits.
      if (r_byte_rdy) begin
        case (r_shift)
          8'hE0: r_ext_pend <= 1'b1;
          8'hF0: r_brk_pend <= 1'b1;
          8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
          default: begin
            r_valid    <= 1'b1;
            r_code     <= r_shift;
            r_make     <= ~r_brk_pend;
            r_ext      <= r_ext_pend;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
        endcase
      end
    end
  end

  assign evt.valid     = r_valid;
  assign evt.makeBreak = r_make;
  assign evt.outCode   = r_code;
  assign evt.extended  = r_ext;
  assign evt.frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_scancode_receiver                                                 |
// | Frame-level PS/2 stimulus against an event-queue model of the receiver.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ps2_scancode_receiver;

  localparam int CLK_FILTER     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int TIMEOUT_W      = 8;
  // Cycles from driving a PS2_CLK fall to the cycle the receiver sees it.
  localparam int FALL_LAT       = 2 + CLK_FILTER - 1;
  localparam int HALF           = 16;
  localparam int GAP            = 20;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk, ps2_dat;

  ps2_scancode_receiver_if evt ();

  ps2_scancode_receiver #(
    .CLK_FILTER    (CLK_FILTER),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         at;
    bit         err;
    logic [7:0] code;
    bit         mk;
    bit         ext;
  } ev_t;

  ev_t        evq[$];
  bit         m_ext, m_brk;
  logic [7:0] h_code;
  bit         h_mk, h_ext;
  int         total = 0, bad = 0;
  int         n_valid = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the scheduled events.
  ev_t  ev;
  logic exp_v, exp_e;
  always @(posedge clk) begin
    #1;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (rst) begin
      h_code = 8'h00;
      h_mk   = 1'b0;
      h_ext  = 1'b0;
    end else begin
      while (evq.size() > 0 && evq[0].at < cyc) begin
        total++;
        bad++;
        $display("FAIL sched: event due at cycle %0d never matched, now %0d", evq[0].at, cyc);
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.err) exp_e = 1'b1;
        else begin
          exp_v  = 1'b1;
          h_code = ev.code;
          h_mk   = ev.mk;
          h_ext  = ev.ext;
        end
      end
    end
    chk("valid",     evt.valid,     exp_v);
    chk("frame_err", evt.frame_err, exp_e);
    chk("outCode",   evt.outCode,   h_code);
    chk("makeBreak", evt.makeBreak, h_mk);
    chk("extended",  evt.extended,  h_ext);
    chk("excl",      evt.valid & evt.frame_err, 1'b0);
    if (evt.valid)     n_valid++;
    if (evt.frame_err) n_err++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input bit err, input logic [7:0] code,
                         input bit mk, input bit ext);
    ev_t e;
    e.at = at; e.err = err; e.code = code; e.mk = mk; e.ext = ext;
    evq.push_back(e);
  endtask

  // Byte-level decoder model: prefixes set flags, housekeeping bytes vanish.
  task automatic model_byte(input logic [7:0] b, input int at);
    case (b)
      8'hE0: m_ext = 1'b1;
      8'hF0: m_brk = 1'b1;
      8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin m_ext = 1'b0; m_brk = 1'b0; end
      default: begin
        push_ev(at, 1'b0, b, ~m_brk, m_ext);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    endcase
  endtask

  task automatic fall_edge(input bit b, input bit glitch, output int fall_at);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 10);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    fall_at = cyc + FALL_LAT;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_at);
    logic [10:0] f;
    int          fa;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      fall_edge(f[i], i == glitch_at, fa);
      if (i == nbits - 1) begin
        if (nbits < 11) begin
          push_ev(fa + TIMEOUT_CYCLES + 1, 1'b1, 8'h00, 1'b0, 1'b0);
          m_ext = 1'b0; m_brk = 1'b0;
        end else if (bad_par || bad_stop) begin
          push_ev(fa + 1, 1'b1, 8'h00, 1'b0, 1'b0);
          m_ext = 1'b0; m_brk = 1'b0;
        end else begin
          model_byte(b, fa + 2);
        end
      end
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1);
  endtask

  int         v0, e0, mode, nb, gl;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(3);
    chk("rst_valid", evt.valid, 1'b0);
    chk("rst_code",  evt.outCode, 8'h00);
    chk("rst_err",   evt.frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(5);

    v0 = n_valid; e0 = n_err;
    good(8'h1C); wait_cyc(GAP);
    chk("1c_count", n_valid - v0, 1);
    chk("1c_err",   n_err - e0, 0);
    chk("1c_code",  evt.outCode, 8'h1C);
    chk("1c_make",  evt.makeBreak, 1'b1);
    chk("1c_ext",   evt.extended, 1'b0);

    v0 = n_valid;
    good(8'hE0); good(8'h74); wait_cyc(GAP);
    chk("e074_count", n_valid - v0, 1);
    chk("e074_code",  evt.outCode, 8'h74);
    chk("e074_ext",   evt.extended, 1'b1);
    chk("e074_make",  evt.makeBreak, 1'b1);

    v0 = n_valid;
    good(8'hE0); good(8'hF0); good(8'h74); wait_cyc(GAP);
    chk("e0f074_count", n_valid - v0, 1);
    chk("e0f074_ext",   evt.extended, 1'b1);
    chk("e0f074_make",  evt.makeBreak, 1'b0);

    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1); wait_cyc(GAP);
    chk("par_err",   n_err - e0, 1);
    chk("par_valid", n_valid - v0, 0);
    good(8'h6B); wait_cyc(GAP);
    chk("6b_code", evt.outCode, 8'h6B);

    e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b0, 5, -1); wait_cyc(TIMEOUT_CYCLES + GAP);
    chk("to_err", n_err - e0, 1);
    good(8'h72); wait_cyc(GAP);
    chk("72_code", evt.outCode, 8'h72);

    v0 = n_valid; e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b0, 11, 4); wait_cyc(GAP);
    chk("glitch_count", n_valid - v0, 1);
    chk("glitch_code",  evt.outCode, 8'h29);
    good(8'hAA); wait_cyc(GAP);
    chk("aa_valid", n_valid - v0, 1);
    chk("aa_err",   n_err - e0, 0);

    good(8'hF0); wait_cyc(GAP);
    rst = 1'b1;
    evq.delete();
    m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(3);
    chk("mrst_code", evt.outCode, 8'h00);
    chk("mrst_make", evt.makeBreak, 1'b0);
    rst = 1'b0;
    wait_cyc(5);
    good(8'h75); wait_cyc(GAP);
    chk("75_code", evt.outCode, 8'h75);
    chk("75_make", evt.makeBreak, 1'b1);

    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 19);
      rb   = 8'($urandom_range(0, 255));
      gl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : -1;
      if (mode == 0) begin
        nb = $urandom_range(1, 10);
        send_frame(rb, 1'b0, 1'b0, nb, -1);
        wait_cyc(TIMEOUT_CYCLES + GAP);
      end else begin
        if (mode <= 3 || mode == 8 || mode == 9) good(8'hE0);
        if ((mode >= 4 && mode <= 7) || mode == 8 || mode == 9) good(8'hF0);
        send_frame(rb, mode == 10, mode == 11, 11, gl);
        wait_cyc(GAP);
      end
    end

    wait_cyc(GAP);
    chk("queue_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
